ni_arbiter_multi: RTL and testbench

Parametrised successor to the two-queue network-interface emitter in the readout network. It buffers NUM_CH producer streams (memory NI, logic NIs, future sources) in per-channel FIFOs and drains them onto one valid/ready link toward the readout router. Arbitration is fixed-priority with a starvation guard so low-priority channels are guaranteed service. It adds a sticky per-channel overflow flag and a source-channel tag on the output.

---
 rtl/ni_pkg.sv | 20 ++
 rtl/ni_chan_fifo.sv | 82 ++++++++
 rtl/ni_arbiter_multi.sv | 129 ++++++++++++
 tb/tb_ni_arbiter_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// Shared constants and helpers for the readout-network interface blocks.
// The default-parameter constants are also used by the readout router.
package ni_pkg;

  // Wait counters are 8 bits wide.
  localparam int STARVE_W = 8;

  // Default configuration shared with the readout router.
  localparam logic [4:0] NI_ID_DEF           = 5'h0;
  localparam int         NI_NUM_CH_DEF       = 2;
  localparam int         NI_DATA_W_DEF       = 32;
  localparam int         NI_DEPTH_DEF        = 4;
  localparam int         NI_STARVE_LIMIT_DEF = 8;

  // Width of a channel index; never less than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ni_chan_fifo.sv
// Per-channel FIFO: registered write, combinational head, registered
// almost-full flag and a sticky overflow flag.
module ni_chan_fifo
  import ni_pkg::*;
#(
  parameter int DATA_W = NI_DATA_W_DEF,
  parameter int DEPTH  = NI_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              ovf_clr_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              afull_q, ovf_q;
  logic              full, push_ok, pop_ok;

  // A push into a completely full FIFO is dropped even if a pop frees a
  // slot in the same cycle; the pop still proceeds.
  assign full    = (count_q == FULL_CNT);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && (count_q != '0);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      afull_q <= (count_d >= AFULL_CNT);
      // Clear wins over a same-cycle overflow event.
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end else if (push_i && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign afull_o = afull_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ni_arbiter_multi.sv
// Multi-channel network-interface emitter: per-channel FIFOs drained onto
// one valid/ready link by a fixed-priority arbiter with a starvation guard.
module ni_arbiter_multi
  import ni_pkg::*;
#(
  parameter logic [4:0] ID           = NI_ID_DEF,
  parameter int         NUM_CH       = NI_NUM_CH_DEF,
  parameter int         DATA_W       = NI_DATA_W_DEF,
  parameter int         DEPTH        = NI_DEPTH_DEF,
  parameter int         STARVE_LIMIT = NI_STARVE_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_CH-1:0]          Wr_i,
  input  logic [NUM_CH*DATA_W-1:0]   WrData_i,
  output logic [NUM_CH-1:0]          Full_o,
  output logic [NUM_CH-1:0]          Overflow_o,
  input  logic                       OvfClr_i,
  output logic                       Valid_o,
  output logic [DATA_W-1:0]          Data_o,
  output logic [ch_w(NUM_CH)-1:0]    Ch_o,
  output logic [4:0]                 Id_o,
  input  logic                       Ready_i
);

  localparam int CW = ch_w(NUM_CH);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [DATA_W-1:0]   head   [NUM_CH];
  logic [STARVE_W-1:0] wait_q [NUM_CH];
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   gnt_oh;
  logic [CW-1:0]       gnt_idx;
  logic                any_req;
  logic                starve_hit;
  logic                load_en;

  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [CW-1:0]       ch_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ni_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push_i    (Wr_i[k]),
      .data_i    (WrData_i[k*DATA_W +: DATA_W]),
      .pop_i     (gnt_oh[k]),
      .ovf_clr_i (OvfClr_i),
      .head_o    (head[k]),
      .empty_o   (empty[k]),
      .afull_o   (Full_o[k]),
      .ovf_o     (Overflow_o[k])
    );
  end

  // The output register accepts a new word when empty or being drained.
  assign load_en = !valid_q || Ready_i;

  // Grant selection: a starved channel overrides plain priority; within each
  // class the lowest index wins (descending scan, last hit kept).
  always_comb begin
    gnt_idx    = '0;
    any_req    = 1'b0;
    starve_hit = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!empty[k]) begin
        any_req = 1'b1;
        gnt_idx = CW'(k);
      end
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!empty[k] && (wait_q[k] == LIMIT)) begin
        starve_hit = 1'b1;
        gnt_idx    = CW'(k);
      end
    end
  end

  // One-hot pop strobe for the granted FIFO, only when the output loads.
  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      gnt_oh[k] = load_en && any_req && (gnt_idx == CW'(k));
    end
  end

  // Per-channel wait counters: cleared when empty or served, otherwise
  // count lost arbitration rounds up to the starvation limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wait_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (empty[k] || gnt_oh[k]) begin
          wait_q[k] <= '0;
        end else if (load_en && (wait_q[k] != LIMIT)) begin
          wait_q[k] <= wait_q[k] + 1'b1;
        end
      end
    end
  end

  // Output stage: loads the granted head word, holds under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else if (load_en) begin
      valid_q <= any_req;
      if (any_req) begin
        data_q <= head[gnt_idx];
        ch_q   <= gnt_idx;
      end
    end
  end

  assign Valid_o = valid_q;
  assign Data_o  = data_q;
  assign Ch_o    = ch_q;
  assign Id_o    = ID;

endmodule

// File: tb/tb_ni_arbiter_multi.sv
// Directed bench for ni_arbiter_multi: two channels, depth 4, starvation
// limit 3, node ID 0x13.
module tb_ni_arbiter_multi;

  logic        clk;
  logic        rstn;
  logic [1:0]  wr;
  logic [63:0] wdata;
  logic [1:0]  full;
  logic [1:0]  ovf;
  logic        ovf_clr;
  logic        valid;
  logic [31:0] data;
  logic [0:0]  ch;
  logic [4:0]  id;
  logic        ready;

  int checks = 0;
  int errors = 0;

  ni_arbiter_multi #(
    .ID           (5'h13),
    .NUM_CH       (2),
    .DATA_W       (32),
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .Wr_i       (wr),
    .WrData_i   (wdata),
    .Full_o     (full),
    .Overflow_o (ovf),
    .OvfClr_i   (ovf_clr),
    .Valid_o    (valid),
    .Data_o     (data),
    .Ch_o       (ch),
    .Id_o       (id),
    .Ready_i    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a valid word, check it, then let it be accepted.
  task automatic pop_check(input string tag, input logic [31:0] exp_data, input logic exp_ch);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_ch"}, 32'(ch), 32'(exp_ch));
    tick();
  endtask

  initial begin
    logic [7:0] seq;
    seq = 8'b1000_1000;

    // Reset held with pushes asserted
    rstn = 1'b0; wr = 2'b11; wdata = 64'h1111_2222_3333_4444;
    ovf_clr = 1'b0; ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_id", 32'(id), 32'h13);
    wr = 2'b00; rstn = 1'b1;
    tick();
    chk("post_rst_valid1", 32'(valid), 32'd0);
    tick();
    chk("post_rst_valid2", 32'(valid), 32'd0);

    // Single push on ch1: two-cycle latency, one-cycle pulse
    ready = 1'b1;
    wr = 2'b10; wdata = {32'hDEADBEEF, 32'h0};
    tick();
    wr = 2'b00;
    chk("single_n1_valid", 32'(valid), 32'd0);
    tick();
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_data", data, 32'hDEADBEEF);
    chk("single_ch", 32'(ch), 32'd1);
    tick();
    chk("single_gone", 32'(valid), 32'd0);

    // Continuous traffic on both channels: starvation guard every 4th word
    wr = 2'b11; wdata = {32'h0000_1001, 32'h0000_0001};
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("cont_valid_%0d", i), 32'(valid), 32'd1);
      chk($sformatf("cont_ch_%0d", i), 32'(ch), 32'(seq[i]));
    end
    wr = 2'b00;
    chk("cont_ovf", 32'(ovf), 32'b10);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("cont_ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("cont_drained", 32'(valid), 32'd0);

    // Backpressure: four words on ch0 while the link stalls
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr = 2'b01; wdata = {32'h0, 32'hA0 + 32'(i)};
      tick();
    end
    wr = 2'b00;
    chk("bp_full", 32'(full), 32'b01);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_%0d", i), data, 32'hA0);
    end
    chk("bp_hold_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("bp_word%0d", i), 32'hA0 + 32'(i), 1'b0);
    end
    chk("bp_empty", 32'(valid), 32'd0);
    chk("bp_full_clear", 32'(full), 32'd0);

    // Overflow: output stage occupied, five pushes into ch1
    ready = 1'b0;
    wr = 2'b01; wdata = {32'h0, 32'hB0};
    tick();
    wr = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr = 2'b10; wdata = {32'hC0 + 32'(i), 32'h0};
      tick();
    end
    wr = 2'b00;
    chk("ovf_flag", 32'(ovf), 32'b10);
    chk("ovf_full", 32'(full), 32'b10);
    ready = 1'b1;
    pop_check("ovf_b0", 32'hB0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("ovf_c%0d", i), 32'hC0 + 32'(i), 1'b1);
    end
    chk("ovf_dropped", 32'(valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'b10);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Wrap-around: 12 words through ch0 at full rate
    for (int i = 0; i < 12; i++) begin
      wr = 2'b01; wdata = {32'h0, 32'hD00 + 32'(i)};
      tick();
      chk($sformatf("wrap_full_%0d", i), 32'(full), 32'd0);
      if (i > 0) begin
        chk($sformatf("wrap_valid_%0d", i), 32'(valid), 32'd1);
        chk($sformatf("wrap_data_%0d", i), data, 32'hD00 + 32'(i - 1));
      end
    end
    wr = 2'b00;
    tick();
    chk("wrap_last", data, 32'hD0B);
    tick();
    chk("wrap_idle", 32'(valid), 32'd0);

    // Reset mid-transfer: Valid_o drops without a clock edge
    ready = 1'b0;
    wr = 2'b01; wdata = {32'h0, 32'hE0};
    tick();
    wdata = {32'h0, 32'hE1};
    tick();
    wr = 2'b00;
    tick();
    chk("mid_valid_before", 32'(valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_async_valid", 32'(valid), 32'd0);
    chk("mid_async_data", data, 32'd0);
    rstn = 1'b1;
    ready = 1'b1;
    tick(); tick(); tick();
    chk("mid_discarded", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
